// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, ALU ops,
// FSM states, PC/register-destination selects and the bundled control word.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_AND  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_XNOR = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_RS  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] REG_RA = 2'b00;
  localparam logic [1:0] REG_RT = 2'b01;
  localparam logic [1:0] REG_RD = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       db_data_src;
    logic       m_rd;
    logic       m_wr;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
  } ctrl_t;

  function automatic logic is_alu_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
      OP_ORI, OP_OR, OP_SLL, OP_SLT, OP_SLTI: is_alu_class = 1'b1;
      default:                                is_alu_class = 1'b0;
    endcase
  endfunction

  // Immediate forms write back to rt; register forms write back to rd.
  function automatic logic is_imm_form(input logic [5:0] op);
    case (op)
      OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: is_imm_form = 1'b1;
      default:                            is_imm_form = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// ALU operand/operation select bundle; the control unit is the master and the
// datapath ALU is the slave returning the zero flag.
interface multicycle_control_unit_if;
  logic [2:0] ALUop;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ExtSel;
  logic       zero;

  modport master (output ALUop, ALUSrcA, ALUSrcB, ExtSel, input zero);
  modport slave  (input ALUop, ALUSrcA, ALUSrcB, ExtSel, output zero);
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode-to-ALU-select decode; don't-care fields are driven 0.
module alu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] opcode,
    output logic [2:0]      alu_op,
    output logic            alu_src_a,
    output logic            alu_src_b,
    output logic            ext_sel
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        case (opcode)
            OP_SUB:         alu_op = ALU_SUB;
            OP_ADDIU:       begin alu_src_b = 1'b1; ext_sel = 1'b1; end
            OP_AND:         alu_op = ALU_AND;
            OP_ANDI:        begin alu_op = ALU_AND; alu_src_b = 1'b1; end
            OP_ORI:         begin alu_op = ALU_OR;  alu_src_b = 1'b1; end
            OP_OR:          alu_op = ALU_OR;
            OP_SLL:         begin alu_op = ALU_SLL; alu_src_a = 1'b1; end
            OP_SLT:         alu_op = ALU_SLT;
            OP_SLTI:        begin alu_op = ALU_SLT; alu_src_b = 1'b1; ext_sel = 1'b1; end
            OP_SW, OP_LW:   begin alu_src_b = 1'b1; ext_sel = 1'b1; end
            OP_BEQ, OP_BNE: begin alu_op = ALU_SUB; ext_sel = 1'b1; end
            default:        ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-subset control FSM (IF/ID/EXE/MEM/WB) with a sticky HALT
// state; outputs decode the registered state and the IR opcode.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] opcode,
    multicycle_control_unit_if.master alu,
    output logic [2:0]      state,
    output logic            PCWre,
    output logic            IRWre,
    output logic            InsMemRW,
    output logic            RegWre,
    output logic [1:0]      RegDst,
    output logic            WrRegDSrc,
    output logic            DBDataSrc,
    output logic            mRD,
    output logic            mWR,
    output logic [1:0]      PCSrc
);

    state_e     state_q, state_d;
    logic       halt_q, halt_d;
    ctrl_t      ctrl, ctrl_out;
    logic [2:0] dec_alu_op;
    logic       dec_src_a, dec_src_b, dec_ext;

    alu_ctrl_decode #(.OP_W(OP_W)) u_dec (
        .opcode    (opcode),
        .alu_op    (dec_alu_op),
        .alu_src_a (dec_src_a),
        .alu_src_b (dec_src_b),
        .ext_sel   (dec_ext)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
            halt_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        ctrl    = '0;
        if (!halt_q) begin
            // ALU selects stay valid from ID through WB so the ALU result holds steady.
            if (state_q != S_IF) begin
                ctrl.alu_op    = dec_alu_op;
                ctrl.alu_src_a = dec_src_a;
                ctrl.alu_src_b = dec_src_b;
                ctrl.ext_sel   = dec_ext;
            end
            case (state_q)
                S_IF: begin
                    ctrl.ins_mem_rw = 1'b1;
                    ctrl.ir_wre     = 1'b1;
                    state_d         = S_ID;
                end
                S_ID: begin
                    if (opcode == HALT_OP) begin
                        halt_d = 1'b1;
                    end else if (opcode == OP_J || opcode == OP_JR || opcode == OP_JAL) begin
                        ctrl.pc_wre = 1'b1;
                        ctrl.pc_src = (opcode == OP_JR) ? PC_RS : PC_JMP;
                        if (opcode == OP_JAL) begin
                            ctrl.reg_wre = 1'b1;
                            ctrl.reg_dst = REG_RA;
                        end
                        state_d = S_IF;
                    end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                        state_d = S_EXE_BR;
                    end else if (opcode == OP_SW || opcode == OP_LW) begin
                        state_d = S_EXE_LS;
                    end else if (is_alu_class(opcode)) begin
                        state_d = S_EXE_AL;
                    end else begin
                        ctrl.pc_wre = 1'b1;
                        state_d     = S_IF;
                    end
                end
                S_EXE_BR: begin
                    ctrl.pc_wre = 1'b1;
                    if ((opcode == OP_BEQ && alu.zero) || (opcode == OP_BNE && !alu.zero))
                        ctrl.pc_src = PC_BR;
                    state_d = S_IF;
                end
                S_EXE_LS: state_d = S_MEM;
                S_MEM: begin
                    if (opcode == OP_SW) begin
                        ctrl.m_wr   = 1'b1;
                        ctrl.pc_wre = 1'b1;
                        state_d     = S_IF;
                    end else begin
                        ctrl.m_rd = 1'b1;
                        state_d   = S_WB_LD;
                    end
                end
                S_WB_LD: begin
                    ctrl.m_rd         = 1'b1;
                    ctrl.db_data_src  = 1'b1;
                    ctrl.wr_reg_d_src = 1'b1;
                    ctrl.reg_dst      = REG_RT;
                    ctrl.reg_wre      = 1'b1;
                    ctrl.pc_wre       = 1'b1;
                    state_d           = S_IF;
                end
                S_EXE_AL: state_d = S_WB_AL;
                S_WB_AL: begin
                    ctrl.reg_wre      = 1'b1;
                    ctrl.wr_reg_d_src = 1'b1;
                    ctrl.reg_dst      = is_imm_form(opcode) ? REG_RT : REG_RD;
                    ctrl.pc_wre       = 1'b1;
                    state_d           = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end
    end

    // Reset forces every output low, including the fetch enables of IF.
    assign ctrl_out = Reset ? ctrl : '0;

    assign state       = state_q;
    assign PCWre       = ctrl_out.pc_wre;
    assign IRWre       = ctrl_out.ir_wre;
    assign InsMemRW    = ctrl_out.ins_mem_rw;
    assign RegWre      = ctrl_out.reg_wre;
    assign RegDst      = ctrl_out.reg_dst;
    assign WrRegDSrc   = ctrl_out.wr_reg_d_src;
    assign DBDataSrc   = ctrl_out.db_data_src;
    assign mRD         = ctrl_out.m_rd;
    assign mWR         = ctrl_out.m_wr;
    assign PCSrc       = ctrl_out.pc_src;
    assign alu.ALUop   = ctrl_out.alu_op;
    assign alu.ALUSrcA = ctrl_out.alu_src_a;
    assign alu.ALUSrcB = ctrl_out.alu_src_b;
    assign alu.ExtSel  = ctrl_out.ext_sel;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle MIPS-subset control FSM. It is the driving end of the ALU interface: it generates ALUop/ALUSrcA/ALUSrcB and consumes the ALU zero flag for branch resolution.
- It also sequences PC, IR, register file, data memory and writeback muxes through IF/ID/EXE/MEM/WB.
- Outputs are a combinational decode of the registered state and the IR opcode.

Parameters:
- OP_W, 6, opcode width.
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.

Ports:
- CLK  in  1  system clock; all state updates occur on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- opcode  in  OP_W  IR[31:26]; stable from ID onward.
- zero  in  1  ALU zero flag, sampled in EXE_BR.
- state  out  3  current state, for debug/trace.
- PCWre  out  1  PC write enable at the next rising edge.
- IRWre  out  1  IR write enable.
- InsMemRW  out  1  instruction memory read; 1 in IF only.
- ALUop  out  3  ALU operation code.
- ALUSrcA  out  1  1 = zero-extended shamt, 0 = rs data.
- ALUSrcB  out  1  1 = extended immediate, 0 = rt data.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- RegWre  out  1  register file write enable.
- RegDst  out  2  write register select: 00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  out  1  register write data: 0 = PC+4, 1 = DB bus.
- DBDataSrc  out  1  DB bus: 0 = ALU result, 1 = memory data.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- PCSrc  out  2  next PC: 00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = jump target.

Behaviour:
- State encoding:
  - IF = 000, ID = 001, EXE_LS = 010, MEM = 011, WB_LD = 100, EXE_BR = 101, EXE_AL = 110, WB_AL = 111.
  - HALT reuses 001 while a held halt flag is set; the flag is reported in state as 001.
- Reset (Reset = 0, asynchronous):
  - State becomes IF and the halt flag clears.
  - While Reset = 0: PCWre, IRWre, RegWre, mWR, mRD are 0; all other outputs are 0.
- IF: InsMemRW = 1, IRWre = 1; next state ID.
- ID, keyed on opcode:
  - j: PCSrc = 11, PCWre = 1; next IF.
  - jr: PCSrc = 10, PCWre = 1; next IF.
  - jal: PCSrc = 11, PCWre = 1, RegWre = 1, RegDst = 00, WrRegDSrc = 0; next IF.
  - HALT_OP: set the halt flag. The FSM stays halted with PCWre = IRWre = RegWre = mWR = 0 until Reset.
  - beq/bne: next EXE_BR.
  - sw/lw: next EXE_LS.
  - ALU-class opcodes: next EXE_AL.
  - Undefined opcode: executes as a NOP; PCWre = 1, PCSrc = 00; next IF.
- Opcode table (opcode -> ALUop, ALUSrcA, ALUSrcB, ExtSel):
  - add 000000 -> 000, 0, 0, x.
  - sub 000001 -> 001, 0, 0, x.
  - addiu 000010 -> 000, 0, 1, 1.
  - and 010000 -> 100, 0, 0, x.
  - andi 010001 -> 100, 0, 1, 0.
  - ori 010010 -> 011, 0, 1, 0.
  - or 010011 -> 011, 0, 0, x.
  - sll 011000 -> 010, 1, 0, x.
  - slt 100110 -> 110, 0, 0, x.
  - slti 100111 -> 110, 0, 1, 1.
  - sw 110000 / lw 110001 -> 000, 0, 1, 1.
  - beq 110100 / bne 110101 -> 001, 0, 0, 1.
  - j 111000, jr 111001, jal 111010: no ALU use.
  - x outputs are driven 0.
- ALU-select hold: ALUop/ALUSrcA/ALUSrcB/ExtSel stay valid for the whole of every EXE, MEM and WB state. The ALU latches its operands on the falling edge inside EXE and its result must remain stable through WB.
- EXE_AL: next WB_AL.
- WB_AL:
  - RegWre = 1, DBDataSrc = 0, WrRegDSrc = 1.
  - RegDst = 01 for immediate forms and 10 otherwise.
  - PCWre = 1, PCSrc = 00; next IF.
- EXE_BR:
  - PCWre = 1.
  - PCSrc = 01 if (beq and zero = 1) or (bne and zero = 0), else 00.
  - zero is combinational within the cycle; next IF.
- EXE_LS: next MEM.
- MEM:
  - sw: mWR = 1, PCWre = 1, PCSrc = 00; next IF.
  - lw: mRD = 1; next WB_LD.
- WB_LD:
  - mRD = 1, DBDataSrc = 1, WrRegDSrc = 1, RegDst = 01, RegWre = 1.
  - PCWre = 1, PCSrc = 00; next IF.
- Cycle counts (IF to the next IF):
  - j/jr/jal/NOP: 2.
  - beq/bne: 3.
  - sw: 4.
  - ALU-class: 4.
  - lw: 5.
- Exactly one PCWre pulse per instruction.
- Reset asserted mid-instruction aborts immediately. No write enable is asserted on the edge at which Reset deasserts; the first fetch follows.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode constants;
  - ALUop codes (ADD = 000 … XNOR = 111);
  - state encodings;
  - PCSrc and RegDst encodings.
- One sub-module: alu_ctrl_decode. It is combinational, maps opcode to ALUop/ALUSrcA/ALUSrcB/ExtSel, and is instanced once.

Test Plan:
- Reset low for 2 cycles mid-WB_AL, then release -> state = 000, all enables 0 during reset; first posedge after release gives IF with IRWre = 1.
- add (000000) -> state 000→001→110→111→000; WB_AL shows RegWre = 1, RegDst = 10, ALUop = 000; exactly 1 PCWre pulse.
- beq with zero = 1, then with zero = 0 -> EXE_BR PCSrc = 01 and then 00; bne with zero = 0 -> PCSrc = 01; each takes 3 cycles.
- lw (110001) -> 5 cycles; MEM mRD = 1; WB_LD DBDataSrc = 1, RegDst = 01, RegWre = 1; sw -> mWR = 1 only in MEM, 4 cycles.
- sll (011000) -> ALUSrcA = 1, ALUop = 010 held through EXE_AL and WB_AL; slti -> ALUop = 110, ALUSrcB = 1, ExtSel = 1.
- jal, then undefined opcode 101010, then 111111 -> jal: 2 cycles, RegDst = 00, WrRegDSrc = 0, PCSrc = 11; NOP: 2 cycles, PCSrc = 00; halt: no further PCWre/IRWre for 20 cycles until Reset.
